// File: rtl/adc_readout.sv
// Serial-ADC readout: convert-start, busy wait with timeout, 16-bit serial shift.
// Define ADC_READOUT_AVG4_EN to average four back-to-back frames per request.
`timescale 1ns/1ps
module adc_readout #(
  parameter int SCLK_DIV     = 2,
  parameter int CONV_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adc_enable,
  input  logic        adc_read,
  input  logic        adc_busy,
  input  logic        adc_sdo,
  output logic        adc_convst,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_conversion_complete,
  output logic [15:0] adc_value,
  output logic        adc_error
);
  localparam int TW = $clog2(CONV_TIMEOUT + 1);
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [TW-1:0] TMO_LAST    = TW'(CONV_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX     = TW'(CONV_TIMEOUT);
  localparam logic [TW-1:0] BUSY_IGNORE = TW'(3);
  localparam logic [DW-1:0] DIV_LAST    = DW'(SCLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, CONVST, WAIT, SHIFT, GAP, DONE} state_t;

  state_t          state_reg;
  logic            read_d_reg;
  logic            busy_meta_reg;
  logic            busy_sync_reg;
  logic [TW-1:0]   tmo_cnt_reg;
  logic [DW-1:0]   div_cnt_reg;
  logic [5:0]      half_cnt_reg;
  logic [15:0]     shift_reg;
  logic            request;
`ifdef ADC_READOUT_AVG4_EN
  logic [1:0]      frame_cnt_reg;
  logic [17:0]     acc_reg;
  logic [17:0]     acc_sum;
  assign acc_sum = acc_reg + {2'b00, shift_reg};
`endif

  assign request = adc_read & ~read_d_reg & adc_enable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg               <= IDLE;
      read_d_reg              <= 1'b1;
      busy_meta_reg           <= 1'b0;
      busy_sync_reg           <= 1'b0;
      tmo_cnt_reg             <= '0;
      div_cnt_reg             <= '0;
      half_cnt_reg            <= '0;
      shift_reg               <= '0;
      adc_convst              <= 1'b0;
      adc_cs_n                <= 1'b1;
      adc_sclk                <= 1'b0;
      adc_conversion_complete <= 1'b0;
      adc_value               <= '0;
      adc_error               <= 1'b0;
`ifdef ADC_READOUT_AVG4_EN
      frame_cnt_reg           <= '0;
      acc_reg                 <= '0;
`endif
    end else begin
      read_d_reg              <= adc_read;
      busy_meta_reg           <= adc_busy;
      busy_sync_reg           <= busy_meta_reg;
      adc_conversion_complete <= 1'b0;
      if (state_reg != IDLE && !adc_enable) begin
        state_reg  <= IDLE;
        adc_cs_n   <= 1'b1;
        adc_sclk   <= 1'b0;
        adc_convst <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (request) begin
              adc_error   <= 1'b0;
              adc_convst  <= 1'b1;
              tmo_cnt_reg <= '0;
              state_reg   <= CONVST;
`ifdef ADC_READOUT_AVG4_EN
              frame_cnt_reg <= '0;
              acc_reg       <= '0;
`endif
            end
          end
          CONVST: begin
            // tmo_cnt_reg doubles as the two-cycle pulse counter here
            if (tmo_cnt_reg[0]) begin
              adc_convst  <= 1'b0;
              tmo_cnt_reg <= '0;
              state_reg   <= WAIT;
            end else begin
              tmo_cnt_reg <= TW'(1);
            end
          end
          WAIT: begin
            // busy is not trusted until the synchroniser has caught the rise
            if (tmo_cnt_reg >= BUSY_IGNORE && !busy_sync_reg) begin
              adc_cs_n     <= 1'b0;
              adc_sclk     <= 1'b0;
              div_cnt_reg  <= '0;
              half_cnt_reg <= '0;
              state_reg    <= SHIFT;
            end else if (tmo_cnt_reg == TMO_LAST) begin
              adc_error   <= 1'b1;
              tmo_cnt_reg <= TMO_MAX;
              state_reg   <= IDLE;
            end else if (tmo_cnt_reg != TMO_MAX) begin
              tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end
          end
          SHIFT: begin
            // half 0 is the initial low hold; odd halves are sclk high
            if (div_cnt_reg == DIV_LAST) begin
              div_cnt_reg <= '0;
              if (half_cnt_reg == 6'd32) begin
                adc_cs_n <= 1'b1;
`ifdef ADC_READOUT_AVG4_EN
                if (frame_cnt_reg == 2'd3) begin
                  adc_value               <= acc_sum[17:2];
                  adc_conversion_complete <= 1'b1;
                  state_reg               <= DONE;
                end else begin
                  acc_reg       <= acc_sum;
                  frame_cnt_reg <= frame_cnt_reg + 1'b1;
                  state_reg     <= GAP;
                end
`else
                adc_value               <= shift_reg;
                adc_conversion_complete <= 1'b1;
                state_reg               <= DONE;
`endif
              end else begin
                half_cnt_reg <= half_cnt_reg + 1'b1;
                adc_sclk     <= ~half_cnt_reg[0];
                if (!half_cnt_reg[0]) begin
                  shift_reg <= {shift_reg[14:0], adc_sdo};
                end
              end
            end else begin
              div_cnt_reg <= div_cnt_reg + 1'b1;
            end
          end
          GAP: begin
            adc_convst  <= 1'b1;
            tmo_cnt_reg <= '0;
            state_reg   <= CONVST;
          end
          DONE: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adc_readout.sv
// Directed bench for adc_readout with a behavioural ADC (busy + serial data).
`timescale 1ns/1ps
module tb_adc_readout;
  logic        clk;
  logic        rst;
  logic        adc_enable;
  logic        adc_read;
  logic        adc_busy;
  logic        adc_sdo;
  logic        adc_convst;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_conversion_complete;
  logic [15:0] adc_value;
  logic        adc_error;

  int n_checks;
  int n_fail;

`ifdef ADC_READOUT_AVG4_EN
  localparam int CONV_WAIT = 500;
`else
  localparam int CONV_WAIT = 150;
`endif

  adc_readout #(.SCLK_DIV(2), .CONV_TIMEOUT(64)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .adc_enable              (adc_enable),
    .adc_read                (adc_read),
    .adc_busy                (adc_busy),
    .adc_sdo                 (adc_sdo),
    .adc_convst              (adc_convst),
    .adc_cs_n                (adc_cs_n),
    .adc_sclk                (adc_sclk),
    .adc_conversion_complete (adc_conversion_complete),
    .adc_value               (adc_value),
    .adc_error               (adc_error)
  );

  always #5 clk = ~clk;

  // ADC model configuration
  logic        busy_stuck = 1'b0;
  int          busy_len = 20;
  logic [15:0] frame_words [4];

  // ADC model and monitor state
  int          busy_cnt = 0;
  int          bit_idx = 0;
  logic [15:0] adc_word = 16'h0;
  logic [1:0]  frame_sel = 2'd0;
  logic        cs_prev = 1'b1;
  logic        sclk_prev = 1'b0;
  logic        convst_prev = 1'b0;
  int          strobe_cnt = 0;
  logic [15:0] strobe_value = 16'h0;
  int          convst_rises = 0;
  int          sclk_rises = 0;
  int          cs_run = 0;
  int          cs_last_run = 0;

  always @(negedge clk) begin
    if (adc_convst) busy_cnt = busy_len;
    else if (busy_cnt != 0) busy_cnt = busy_cnt - 1;
    adc_busy = busy_stuck || (busy_cnt != 0);
    if (adc_cs_n) begin
      bit_idx = 0;
    end else if (cs_prev) begin
      adc_word  = frame_words[frame_sel];
      frame_sel = frame_sel + 2'd1;
    end else if (sclk_prev && !adc_sclk) begin
      bit_idx = bit_idx + 1;
    end
    adc_sdo = (bit_idx < 16) ? adc_word[15 - bit_idx] : 1'b0;

    if (adc_conversion_complete) begin
      strobe_cnt   = strobe_cnt + 1;
      strobe_value = adc_value;
      $display("[%0t] conversion complete value=0x%h error=%0b", $time, adc_value, adc_error);
    end
    if (adc_convst && !convst_prev) convst_rises = convst_rises + 1;
    if (adc_sclk && !sclk_prev) sclk_rises = sclk_rises + 1;
    if (!adc_cs_n) cs_run = cs_run + 1;
    else begin
      if (cs_run != 0) cs_last_run = cs_run;
      cs_run = 0;
    end
    cs_prev     = adc_cs_n;
    sclk_prev   = adc_sclk;
    convst_prev = adc_convst;
  end

  task automatic set_word(input logic [15:0] w);
    for (int i = 0; i < 4; i++) frame_words[i] = w;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks += 6;
    if (adc_convst !== 1'b0) begin n_fail++; $display("FAIL reset_convst: got %b expected 0", adc_convst); end
    if (adc_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", adc_cs_n); end
    if (adc_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", adc_sclk); end
    if (adc_conversion_complete !== 1'b0) begin n_fail++; $display("FAIL reset_complete: got %b expected 0", adc_conversion_complete); end
    if (adc_value !== 16'h0000) begin n_fail++; $display("FAIL reset_value: got 0x%h expected 0x0000", adc_value); end
    if (adc_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", adc_error); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_read();
    int s0;
    set_word(16'hA5C3);
    busy_len = 20;
    s0 = strobe_cnt;
    @(negedge clk); adc_read = 1'b1;
    @(negedge clk); adc_read = 1'b0;
    n_checks++;
    if (adc_convst !== 1'b1) begin n_fail++; $display("FAIL single_convst_rise: got %b expected 1", adc_convst); end
    @(negedge clk);
    n_checks++;
    if (adc_convst !== 1'b1) begin n_fail++; $display("FAIL single_convst_width2: got %b expected 1", adc_convst); end
    @(negedge clk);
    n_checks++;
    if (adc_convst !== 1'b0) begin n_fail++; $display("FAIL single_convst_fall: got %b expected 0", adc_convst); end
    repeat (CONV_WAIT) @(negedge clk);
    n_checks += 4;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL single_strobes: got %0d expected 1", strobe_cnt - s0); end
    if (strobe_value !== 16'hA5C3) begin n_fail++; $display("FAIL single_strobe_value: got 0x%h expected 0xa5c3", strobe_value); end
    if (adc_value !== 16'hA5C3) begin n_fail++; $display("FAIL single_value: got 0x%h expected 0xa5c3", adc_value); end
    if (cs_last_run !== 66) begin n_fail++; $display("FAIL single_cs_low: got %0d expected 66", cs_last_run); end
  endtask

  task automatic test_timeout();
    int s0;
    int c0;
    int n;
    busy_stuck = 1'b1;
    s0 = strobe_cnt;
    c0 = sclk_rises;
    repeat (3) @(negedge clk);
    @(negedge clk); adc_read = 1'b1;
    @(negedge clk); adc_read = 1'b0;
    n = 0;
    while (adc_convst && n < 10) begin @(negedge clk); n++; end
    n_checks++;
    if (adc_convst !== 1'b0) begin n_fail++; $display("FAIL timeout_convst_end: got %b expected 0", adc_convst); end
    n = 0;
    while (!adc_error && n < 200) begin @(negedge clk); n++; end
    n_checks += 4;
    if (n !== 64) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 64", n); end
    if (adc_error !== 1'b1) begin n_fail++; $display("FAIL timeout_error: got %b expected 1", adc_error); end
    if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL timeout_strobes: got %0d expected 0", strobe_cnt - s0); end
    if (sclk_rises - c0 !== 0) begin n_fail++; $display("FAIL timeout_sclk: got %0d rises expected 0", sclk_rises - c0); end

    busy_stuck = 1'b0;
    set_word(16'h1234);
    repeat (5) @(negedge clk);
    n_checks++;
    if (adc_error !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", adc_error); end
    s0 = strobe_cnt;
    @(negedge clk); adc_read = 1'b1;
    @(negedge clk); adc_read = 1'b0;
    n_checks++;
    if (adc_error !== 1'b0) begin n_fail++; $display("FAIL timeout_error_clear: got %b expected 0", adc_error); end
    repeat (CONV_WAIT) @(negedge clk);
    n_checks += 2;
    if (adc_value !== 16'h1234) begin n_fail++; $display("FAIL timeout_recover_value: got 0x%h expected 0x1234", adc_value); end
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL timeout_recover_strobes: got %0d expected 1", strobe_cnt - s0); end
  endtask

  task automatic test_abort();
    int s0;
    int r0;
    int n;
    set_word(16'hBEEF);
    s0 = strobe_cnt;
    r0 = sclk_rises;
    @(negedge clk); adc_read = 1'b1;
    @(negedge clk); adc_read = 1'b0;
    n = 0;
    while ((sclk_rises - r0) < 8 && n < 300) begin @(negedge clk); n++; end
    n_checks++;
    if (sclk_rises - r0 !== 8) begin n_fail++; $display("FAIL abort_reach_bit8: got %0d rises expected 8", sclk_rises - r0); end
    adc_enable = 1'b0;
    @(negedge clk);
    n_checks += 3;
    if (adc_cs_n !== 1'b1) begin n_fail++; $display("FAIL abort_cs_n: got %b expected 1", adc_cs_n); end
    if (adc_sclk !== 1'b0) begin n_fail++; $display("FAIL abort_sclk: got %b expected 0", adc_sclk); end
    if (adc_convst !== 1'b0) begin n_fail++; $display("FAIL abort_convst: got %b expected 0", adc_convst); end
    repeat (3) @(negedge clk);
    adc_enable = 1'b1;
    repeat (CONV_WAIT) @(negedge clk);
    n_checks += 3;
    if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL abort_strobes: got %0d expected 0", strobe_cnt - s0); end
    if (adc_value !== 16'h1234) begin n_fail++; $display("FAIL abort_value_held: got 0x%h expected 0x1234", adc_value); end
    if (adc_error !== 1'b0) begin n_fail++; $display("FAIL abort_error_held: got %b expected 0", adc_error); end
  endtask

  task automatic test_edge_handling();
    int s0;
    int v0;
    int n;
    set_word(16'h3C69);
    s0 = strobe_cnt;
    v0 = convst_rises;
    @(negedge clk); adc_read = 1'b1;
    repeat (2 * CONV_WAIT) @(negedge clk);
    adc_read = 1'b0;
    n_checks += 3;
    if (convst_rises - v0 !== 1) begin n_fail++; $display("FAIL edge_held_convst: got %0d expected 1", convst_rises - v0); end
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL edge_held_strobes: got %0d expected 1", strobe_cnt - s0); end
    if (adc_value !== 16'h3C69) begin n_fail++; $display("FAIL edge_held_value: got 0x%h expected 0x3c69", adc_value); end

    set_word(16'h5A5A);
    repeat (2) @(negedge clk);
    s0 = strobe_cnt;
    v0 = convst_rises;
    @(negedge clk); adc_read = 1'b1;
    @(negedge clk); adc_read = 1'b0;
    n = 0;
    while (adc_cs_n && n < 100) begin @(negedge clk); n++; end
    n_checks++;
    if (adc_cs_n !== 1'b0) begin n_fail++; $display("FAIL edge_shift_entry: got cs_n %b expected 0", adc_cs_n); end
    repeat (10) @(negedge clk);
    adc_read = 1'b1;
    @(negedge clk); adc_read = 1'b0;
    repeat (CONV_WAIT) @(negedge clk);
    n_checks += 3;
    if (convst_rises - v0 !== 1) begin n_fail++; $display("FAIL edge_shift_convst: got %0d expected 1", convst_rises - v0); end
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL edge_shift_strobes: got %0d expected 1", strobe_cnt - s0); end
    if (adc_value !== 16'h5A5A) begin n_fail++; $display("FAIL edge_shift_value: got 0x%h expected 0x5a5a", adc_value); end
  endtask

  task automatic test_reset_mid_shift();
    int s0;
    int v0;
    int n;
    set_word(16'h0F0F);
    @(negedge clk); adc_read = 1'b1;
    @(negedge clk); adc_read = 1'b0;
    n = 0;
    while (adc_cs_n && n < 100) begin @(negedge clk); n++; end
    repeat (13) @(negedge clk);
    n_checks++;
    if (adc_cs_n !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_shift: got cs_n %b expected 0", adc_cs_n); end
    #2 rst = 1'b1;
    adc_read = 1'b1;
    #1;
    n_checks += 6;
    if (adc_convst !== 1'b0) begin n_fail++; $display("FAIL rstmid_convst: got %b expected 0", adc_convst); end
    if (adc_cs_n !== 1'b1) begin n_fail++; $display("FAIL rstmid_cs_n: got %b expected 1", adc_cs_n); end
    if (adc_sclk !== 1'b0) begin n_fail++; $display("FAIL rstmid_sclk: got %b expected 0", adc_sclk); end
    if (adc_conversion_complete !== 1'b0) begin n_fail++; $display("FAIL rstmid_complete: got %b expected 0", adc_conversion_complete); end
    if (adc_value !== 16'h0000) begin n_fail++; $display("FAIL rstmid_value: got 0x%h expected 0x0000", adc_value); end
    if (adc_error !== 1'b0) begin n_fail++; $display("FAIL rstmid_error: got %b expected 0", adc_error); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0 = strobe_cnt;
    v0 = convst_rises;
    repeat (CONV_WAIT) @(negedge clk);
    n_checks += 2;
    if (convst_rises - v0 !== 0) begin n_fail++; $display("FAIL rstmid_held_read_convst: got %0d expected 0", convst_rises - v0); end
    if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL rstmid_held_read_strobes: got %0d expected 0", strobe_cnt - s0); end
    adc_read = 1'b0;
    @(negedge clk); adc_read = 1'b1;
    @(negedge clk); adc_read = 1'b0;
    repeat (CONV_WAIT) @(negedge clk);
    n_checks += 2;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL rstmid_fresh_strobes: got %0d expected 1", strobe_cnt - s0); end
    if (adc_value !== 16'h0F0F) begin n_fail++; $display("FAIL rstmid_fresh_value: got 0x%h expected 0x0f0f", adc_value); end
  endtask

`ifdef ADC_READOUT_AVG4_EN
  task automatic test_avg4();
    int s0;
    // frame order is irrelevant to the sum: 0x4006 >> 2 = 0x1001
    frame_words[0] = 16'h1000;
    frame_words[1] = 16'h1001;
    frame_words[2] = 16'h1002;
    frame_words[3] = 16'h1003;
    s0 = strobe_cnt;
    @(negedge clk); adc_read = 1'b1;
    @(negedge clk); adc_read = 1'b0;
    repeat (CONV_WAIT) @(negedge clk);
    n_checks += 2;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL avg4_strobes: got %0d expected 1", strobe_cnt - s0); end
    if (adc_value !== 16'h1001) begin n_fail++; $display("FAIL avg4_value: got 0x%h expected 0x1001", adc_value); end
  endtask
`endif

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    adc_enable = 1'b1;
    adc_read   = 1'b0;
    adc_busy   = 1'b0;
    adc_sdo    = 1'b0;
    n_checks   = 0;
    n_fail     = 0;
    set_word(16'h0000);
    test_reset();
    test_single_read();
    test_timeout();
    test_abort();
    test_edge_handling();
    test_reset_mid_shift();
`ifdef ADC_READOUT_AVG4_EN
    test_avg4();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
